// File: rtl/execute_mem_storedrain_if.sv
// Store-drain signal bundle: ROB/store-buffer side, D-cache write port and AXI write channels.
// master = the drain engine, slave = its environment (ROB, store buffer, cache, bus).
interface execute_mem_storedrain_if;
  logic        snoop_hit;
  logic        bco_valid;
  logic        rob_commit_st;
  logic        commit_stall;
  logic        sb_valid;
  logic [31:0] sb_addr;
  logic [3:0]  sb_strb;
  logic [1:0]  sb_lswidth;
  logic [31:0] sb_data;
  logic        sb_uncached;
  logic        sb_wec;
  logic        dcw_en;
  logic [31:0] dcw_addr;
  logic [3:0]  dcw_strb;
  logic [31:0] dcw_data;
  logic        dcw_ready;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  logic        bus_err;

  modport master (
    input  snoop_hit, bco_valid, rob_commit_st,
    input  sb_valid, sb_addr, sb_strb, sb_lswidth, sb_data, sb_uncached,
    input  dcw_ready, aw_ready, w_ready, b_valid, b_resp,
    output commit_stall, sb_wec,
    output dcw_en, dcw_addr, dcw_strb, dcw_data,
    output aw_valid, aw_addr, aw_size,
    output w_valid, w_data, w_strb, w_last,
    output b_ready, bus_err
  );

  modport slave (
    output snoop_hit, bco_valid, rob_commit_st,
    output sb_valid, sb_addr, sb_strb, sb_lswidth, sb_data, sb_uncached,
    output dcw_ready, aw_ready, w_ready, b_valid, b_resp,
    input  commit_stall, sb_wec,
    input  dcw_en, dcw_addr, dcw_strb, dcw_data,
    input  aw_valid, aw_addr, aw_size,
    input  w_valid, w_data, w_strb, w_last,
    input  b_ready, bus_err
  );
endinterface

// File: rtl/execute_mem_storedrain.sv
// Drains committed stores from the store buffer head to the D-cache (cached) or AXI (uncached).
// Optional STOREDRAIN_PERF_EN adds o_perf_cached/o_perf_uncached completed-write counters.
module execute_mem_storedrain #(
  parameter int PEND_MAX = 6,
  parameter int PEND_W   = 3
) (
  input  logic clk,
  input  logic reset,
  execute_mem_storedrain_if.master io_sd
`ifdef STOREDRAIN_PERF_EN
  ,
  output logic [31:0] o_perf_cached,
  output logic [31:0] o_perf_uncached
`endif
);

  typedef enum logic [1:0] {IDLE, CW, UA, UB} state_t;

  state_t            r_state;
  logic [PEND_W-1:0] r_pend_cnt;
  logic              r_abort;
  logic              r_aw_valid;
  logic              r_w_valid;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [3:0]        r_strb;
  logic [1:0]        r_lswidth;

  logic w_flush;
  logic w_start;
  logic w_cw_done;
  logic w_b_done;
  logic w_resp_err;
  logic w_wec;
  logic w_aw_left;
  logic w_w_left;

  assign w_flush    = io_sd.snoop_hit | io_sd.bco_valid;
  assign w_start    = (r_state == IDLE) && (r_pend_cnt != '0) && io_sd.sb_valid && !w_flush;
  assign w_cw_done  = (r_state == CW) && io_sd.dcw_ready;
  assign w_b_done   = (r_state == UB) && io_sd.b_valid;
  assign w_resp_err = (io_sd.b_resp == 2'b10) || (io_sd.b_resp == 2'b11);
  // A flush on the completing cycle still suppresses the pop; the write itself is not undone.
  assign w_wec      = io_sd.sb_valid && !w_flush &&
                      (w_cw_done || (w_b_done && !r_abort));
  assign w_aw_left  = r_aw_valid && !io_sd.aw_ready;
  assign w_w_left   = r_w_valid && !io_sd.w_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_cnt <= '0;
    end else if (w_flush) begin
      r_pend_cnt <= '0;
    end else if (io_sd.rob_commit_st && !w_wec) begin
      r_pend_cnt <= r_pend_cnt + PEND_W'(1);
    end else if (!io_sd.rob_commit_st && w_wec) begin
      r_pend_cnt <= r_pend_cnt - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_abort    <= 1'b0;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_strb     <= '0;
      r_lswidth  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr     <= io_sd.sb_addr;
            r_data     <= io_sd.sb_data;
            r_strb     <= io_sd.sb_strb;
            r_lswidth  <= io_sd.sb_lswidth;
            r_aw_valid <= io_sd.sb_uncached;
            r_w_valid  <= io_sd.sb_uncached;
            r_state    <= io_sd.sb_uncached ? UA : CW;
          end
        end
        CW: begin
          if (w_flush || io_sd.dcw_ready) begin
            r_state <= IDLE;
          end
        end
        UA: begin
          // AW and W complete independently; leave once neither is still outstanding.
          if (r_aw_valid && io_sd.aw_ready) begin
            r_aw_valid <= 1'b0;
          end
          if (r_w_valid && io_sd.w_ready) begin
            r_w_valid <= 1'b0;
          end
          if (!w_aw_left && !w_w_left) begin
            r_state <= UB;
          end
          if (w_flush) begin
            r_abort <= 1'b1;
          end
        end
        UB: begin
          if (io_sd.b_valid) begin
            r_state <= IDLE;
            r_abort <= 1'b0;
          end else if (w_flush) begin
            r_abort <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_sd.commit_stall = (r_pend_cnt == PEND_W'(PEND_MAX));
  assign io_sd.sb_wec       = w_wec;
  assign io_sd.dcw_en       = (r_state == CW);
  assign io_sd.dcw_addr     = r_addr;
  assign io_sd.dcw_strb     = r_strb;
  assign io_sd.dcw_data     = r_data;
  assign io_sd.aw_valid     = r_aw_valid;
  assign io_sd.aw_addr      = r_addr;
  assign io_sd.aw_size      = {1'b0, r_lswidth};
  assign io_sd.w_valid      = r_w_valid;
  assign io_sd.w_data       = r_data;
  assign io_sd.w_strb       = r_strb;
  assign io_sd.w_last       = 1'b1;
  assign io_sd.b_ready      = (r_state == UB);
  assign io_sd.bus_err      = w_b_done && w_resp_err;

`ifdef STOREDRAIN_PERF_EN
  logic [31:0] r_perf_cached;
  logic [31:0] r_perf_uncached;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cached   <= '0;
      r_perf_uncached <= '0;
    end else if (w_wec) begin
      if (r_state == CW) begin
        r_perf_cached <= r_perf_cached + 32'd1;
      end else begin
        r_perf_uncached <= r_perf_uncached + 32'd1;
      end
    end
  end

  assign o_perf_cached   = r_perf_cached;
  assign o_perf_uncached = r_perf_uncached;
`endif

endmodule

// File: tb/tb_execute_mem_storedrain.sv
// Bench for execute_mem_storedrain: store-buffer model, D-cache/AXI responders and a write scoreboard.
module tb_execute_mem_storedrain;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  lsw;
    logic        unc;
    logic        expWec;
  } store_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_mem_storedrain_if sd ();

`ifdef STOREDRAIN_PERF_EN
  logic [31:0] perfCached;
  logic [31:0] perfUncached;
  execute_mem_storedrain dut (.clk(clk), .reset(reset), .io_sd(sd),
                              .o_perf_cached(perfCached), .o_perf_uncached(perfUncached));
`else
  execute_mem_storedrain dut (.clk(clk), .reset(reset), .io_sd(sd));
`endif

  store_t sbQ[$];
  store_t expQ[$];
  int vectors, miscompares;
  int cyc, lastCommitCycle;
  int wecCount, lastWecCycle, lastBCycle, lastAwCycle, lastWCycle;
  bit wecSeen, flushSeen, awDone, wDone;
  int awAge, wAge, bAge, awDelay, wDelay, bDelay;
  logic [1:0] bResp;
  logic dcwReady;
  int c0, w1, w2;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic driveHead();
    if (sbQ.size() != 0) begin
      sd.sb_valid    = 1'b1;
      sd.sb_addr     = sbQ[0].addr;
      sd.sb_data     = sbQ[0].data;
      sd.sb_strb     = sbQ[0].strb;
      sd.sb_lswidth  = sbQ[0].lsw;
      sd.sb_uncached = sbQ[0].unc;
    end else begin
      sd.sb_valid    = 1'b0;
      sd.sb_addr     = '0;
      sd.sb_data     = '0;
      sd.sb_strb     = '0;
      sd.sb_lswidth  = '0;
      sd.sb_uncached = 1'b0;
    end
  endtask

  // Sampled at the falling edge: scoreboard compares against the oldest outstanding store.
  task automatic monitor();
    store_t h;
    bit dcwHs, awHs, wHs, bHs;
    dcwHs = sd.dcw_en && sd.dcw_ready;
    awHs  = sd.aw_valid && sd.aw_ready;
    wHs   = sd.w_valid && sd.w_ready;
    bHs   = sd.b_valid && sd.b_ready;
    flushSeen = sd.snoop_hit || sd.bco_valid;
    wecSeen   = sd.sb_wec;
    if (sd.rob_commit_st) checkOutput("commit_while_stalled", sd.commit_stall, 1'b0);
    if (awDone) checkOutput("aw_valid_dropped", sd.aw_valid, 1'b0);
    if (wDone)  checkOutput("w_valid_dropped", sd.w_valid, 1'b0);
    if (sd.sb_wec) checkOutput("wec_with_sb_valid", sd.sb_valid, 1'b1);
    if (dcwHs || awHs || wHs || bHs) begin
      if (expQ.size() == 0) begin
        checkOutput("write_without_store", dcwHs | awHs | wHs | bHs, 1'b0);
      end else begin
        h = expQ[0];
        if (dcwHs) begin
          checkOutput("dcw_uncached", h.unc, 1'b0);
          checkOutput("dcw_addr", sd.dcw_addr, h.addr);
          checkOutput("dcw_data", sd.dcw_data, h.data);
          checkOutput("dcw_strb", sd.dcw_strb, h.strb);
          checkOutput("dcw_wec", sd.sb_wec, h.expWec);
          void'(expQ.pop_front());
        end
        if (awHs) begin
          checkOutput("aw_uncached", h.unc, 1'b1);
          checkOutput("aw_addr", sd.aw_addr, h.addr);
          checkOutput("aw_size", sd.aw_size, {1'b0, h.lsw});
          awDone = 1'b1;
          lastAwCycle = cyc;
        end
        if (wHs) begin
          checkOutput("w_data", sd.w_data, h.data);
          checkOutput("w_strb", sd.w_strb, h.strb);
          checkOutput("w_last", sd.w_last, 1'b1);
          wDone = 1'b1;
          lastWCycle = cyc;
        end
        if (bHs) begin
          checkOutput("b_wec", sd.sb_wec, h.expWec);
          checkOutput("bus_err", sd.bus_err, bResp[1]);
          lastBCycle = cyc;
          awDone = 1'b0;
          wDone = 1'b0;
          void'(expQ.pop_front());
        end
      end
    end else begin
      if (sd.sb_wec)  checkOutput("spurious_wec", sd.sb_wec, 1'b0);
      if (sd.bus_err) checkOutput("spurious_bus_err", sd.bus_err, 1'b0);
    end
    if (sd.sb_wec) begin
      wecCount++;
      lastWecCycle = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (flushSeen) sbQ.delete();
    else if (wecSeen && sbQ.size() != 0) void'(sbQ.pop_front());
    sd.rob_commit_st = 1'b0;
    sd.snoop_hit     = 1'b0;
    sd.bco_valid     = 1'b0;
    sd.aw_ready = sd.aw_valid && (awAge >= awDelay);
    awAge = sd.aw_valid ? awAge + 1 : 0;
    sd.w_ready = sd.w_valid && (wAge >= wDelay);
    wAge = sd.w_valid ? wAge + 1 : 0;
    sd.b_valid = sd.b_ready && (bAge >= bDelay);
    bAge = sd.b_ready ? bAge + 1 : 0;
    sd.b_resp = sd.b_valid ? bResp : 2'b00;
    sd.dcw_ready = dcwReady;
    driveHead();
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] lsw, input logic unc);
    store_t s;
    s.addr = addr;
    s.data = data;
    s.strb = strb;
    s.lsw = lsw;
    s.unc = unc;
    s.expWec = 1'b1;
    sbQ.push_back(s);
    expQ.push_back(s);
    sd.rob_commit_st = 1'b1;
    lastCommitCycle = cyc;
    driveHead();
  endtask

  task automatic waitWec(input int budget, input string tag);
    int startCount;
    int n;
    startCount = wecCount;
    n = 0;
    do begin
      tick();
      n++;
    end while (wecCount == startCount && n < budget);
    if (wecCount == startCount) checkOutput({tag, "_timeout"}, wecCount - startCount, 1);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; wecCount = 0;
    lastWecCycle = 0; lastBCycle = 0; lastAwCycle = 0; lastWCycle = 0; lastCommitCycle = 0;
    wecSeen = 0; flushSeen = 0; awDone = 0; wDone = 0;
    awAge = 0; wAge = 0; bAge = 0; awDelay = 0; wDelay = 0; bDelay = 0;
    bResp = 2'b00; dcwReady = 1'b0;
    reset = 1'b1;
    sd.snoop_hit = 0; sd.bco_valid = 0; sd.rob_commit_st = 0;
    sd.dcw_ready = 0; sd.aw_ready = 0; sd.w_ready = 0; sd.b_valid = 0; sd.b_resp = 0;
    driveHead();
    repeat (3) tick();
    reset = 1'b0;

    checkOutput("rst_dcw_en", sd.dcw_en, 1'b0);
    checkOutput("rst_aw_valid", sd.aw_valid, 1'b0);
    checkOutput("rst_w_valid", sd.w_valid, 1'b0);
    checkOutput("rst_b_ready", sd.b_ready, 1'b0);
    checkOutput("rst_sb_wec", sd.sb_wec, 1'b0);
    checkOutput("rst_bus_err", sd.bus_err, 1'b0);
    checkOutput("rst_commit_stall", sd.commit_stall, 1'b0);
    checkOutput("rst_w_last", sd.w_last, 1'b1);
    checkOutput("rst_dcw_addr", sd.dcw_addr, 32'h0);

    // Cached drain: start one cycle after commit, dcw handshake the cycle after that.
    dcwReady = 1'b1; sd.dcw_ready = 1'b1;
    applyStimulus(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 2'b10, 1'b0);
    c0 = lastCommitCycle;
    waitWec(10, "t1");
    checkOutput("t1_latency", lastWecCycle - c0, 2);

    // Uncached byte store with a slow AW slave and an immediate W slave.
    awDelay = 3;
    applyStimulus(32'hBFD0_0003, 32'h5A00_0000, 4'b1000, 2'b00, 1'b1);
    c0 = lastCommitCycle;
    waitWec(20, "t2");
    checkOutput("t2_w_cycle", lastWCycle - c0, 2);
    checkOutput("t2_aw_cycle", lastAwCycle - c0, 5);
    checkOutput("t2_wec_cycle", lastWecCycle - c0, 6);
    awDelay = 0;

    // Commit coinciding with a pop keeps the pending count; drains follow back to back.
    dcwReady = 1'b0; sd.dcw_ready = 1'b0;
    applyStimulus(32'h0000_0200, 32'h1111_1111, 4'hF, 2'b10, 1'b0);
    c0 = lastCommitCycle;
    tick();
    applyStimulus(32'h0000_0204, 32'h2222_2222, 4'hF, 2'b10, 1'b0);
    repeat (3) tick();
    applyStimulus(32'h0000_0208, 32'h3333_3333, 4'hF, 2'b10, 1'b0);
    dcwReady = 1'b1; sd.dcw_ready = 1'b1;
    waitWec(5, "t3a");
    w1 = lastWecCycle;
    checkOutput("t3_first", w1 - c0, 4);
    waitWec(5, "t3b");
    w2 = lastWecCycle;
    checkOutput("t3_second", w2 - w1, 2);
    waitWec(5, "t3c");
    checkOutput("t3_third", lastWecCycle - w2, 2);

    // Branch-commit flush while waiting for B: bus completes, no pop, next store waits for IDLE.
    bDelay = 3;
    applyStimulus(32'hBFD0_0010, 32'hCAFE_F00D, 4'hF, 2'b10, 1'b1);
    c0 = lastCommitCycle;
    repeat (3) tick();
    checkOutput("t4_in_ub", sd.b_ready, 1'b1);
    sd.bco_valid = 1'b1;
    expQ[0].expWec = 1'b0;
    tick();
    applyStimulus(32'h0000_0300, 32'h4444_4444, 4'hF, 2'b10, 1'b0);
    waitWec(20, "t4");
    checkOutput("t4_b_cycle", lastBCycle - c0, 6);
    checkOutput("t4_after_idle", lastWecCycle - lastBCycle, 2);
    bDelay = 0;

    // Uncached halfword with SLVERR response.
    bResp = 2'b10;
    applyStimulus(32'hBFD0_0020, 32'h0000_BEEF, 4'b0011, 2'b01, 1'b1);
    c0 = lastCommitCycle;
    waitWec(20, "t6");
    checkOutput("t6_wec_cycle", lastWecCycle - c0, 3);
    tick();
    checkOutput("t6_bus_err_pulse", sd.bus_err, 1'b0);
    bResp = 2'b00;

    // Six commits with the cache blocked: stall exactly at six, released by one drain.
    dcwReady = 1'b0; sd.dcw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(32'(32'h400 + 4 * i), 32'(32'hA000_0000 + i), 4'hF, 2'b10, 1'b0);
      tick();
      checkOutput($sformatf("t5_stall_%0d", i + 1), sd.commit_stall, (i == 5));
    end
    dcwReady = 1'b1; sd.dcw_ready = 1'b1;
    waitWec(5, "t5_drain1");
    checkOutput("t5_unstall", sd.commit_stall, 1'b0);
    for (int i = 0; i < 5; i++) waitWec(5, "t5_drain");
    repeat (3) tick();
    checkOutput("t5_all_written", expQ.size(), 0);

`ifdef STOREDRAIN_PERF_EN
    checkOutput("perf_cached", perfCached, 32'd11);
    checkOutput("perf_uncached", perfUncached, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, vectors %0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
